// File: rtl/axi_pim_pkg.sv
// rtl/axi_pim_pkg.sv - shared AXI burst/response constants and FSM encodings for the PIM SIMD block
package axi_pim_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_DATA,
        WR_RESP
    } wr_state_e;

    typedef enum logic {
        RD_IDLE,
        RD_DATA
    } rd_state_e;

    typedef enum logic [2:0] {
        MAC_IDLE,
        MAC_RD_A,
        MAC_RD_B,
        MAC_ACC,
        MAC_DONE
    } mac_state_e;

    // Only FIXED and INCR touch memory; WRAP and the reserved encoding are answered with SLVERR.
    function automatic logic burst_ok(input logic [1:0] burst);
        return (burst == BURST_FIXED) || (burst == BURST_INCR);
    endfunction

endpackage

// File: rtl/axi_pim_dot.sv
// rtl/axi_pim_dot.sv - combinational signed int8 per-lane product sum of two memory words
module axi_pim_dot #(
    parameter int LANES     = 4,
    parameter int OUT_WIDTH = 40
) (
    input  logic [8*LANES-1:0] a_i,
    input  logic [8*LANES-1:0] b_i,
    output logic [OUT_WIDTH-1:0] sum_o
);

    logic signed [7:0]  lane_a;
    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_p;

    always_comb begin
        sum_o  = '0;
        lane_a = '0;
        lane_b = '0;
        lane_p = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_a = a_i[i*8 +: 8];
            lane_b = b_i[i*8 +: 8];
            lane_p = lane_a * lane_b;
            sum_o  = sum_o + {{(OUT_WIDTH-16){lane_p[15]}}, lane_p};
        end
    end

endmodule

// File: rtl/axi_pim_simd.sv
// rtl/axi_pim_simd.sv - AXI4 slave word memory with an in-memory int8 SIMD dot-product engine
module axi_pim_simd
    import axi_pim_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awlock,
    input  logic [3:0]            s_axi_awcache,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arlock,
    input  logic [3:0]            s_axi_arcache,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    input  logic                  mac_start,
    input  logic [ADDR_WIDTH-1:0] mac_src_a,
    input  logic [ADDR_WIDTH-1:0] mac_src_b,
    input  logic [15:0]           mac_len,
    output logic                  mac_busy,
    output logic                  mac_done,
    output logic [ACC_WIDTH-1:0]  mac_out
);

    localparam int LSB   = $clog2(STRB_WIDTH);
    localparam int WAW   = ADDR_WIDTH - LSB;
    localparam int DEPTH = 1 << WAW;
    localparam logic [WAW-1:0] IDX_ONE = WAW'(1);

    // Not reset: contents must survive a reset that aborts a burst or a MAC run.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    wr_state_e  wr_state_q,  wr_state_d;
    rd_state_e  rd_state_q,  rd_state_d;
    mac_state_e mac_state_q, mac_state_d;

    logic [ID_WIDTH-1:0]   wr_id_q;
    logic [WAW-1:0]        wr_addr_q;
    logic [1:0]            wr_burst_q;

    logic [ID_WIDTH-1:0]   rd_id_q;
    logic [WAW-1:0]        rd_addr_q;
    logic [1:0]            rd_burst_q;
    logic [7:0]            rd_len_q;
    logic [7:0]            rd_beat_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_last_q;

    logic [WAW-1:0]        mac_a_idx_q, mac_b_idx_q;
    logic [DATA_WIDTH-1:0] mac_a_q, mac_b_q;
    logic [15:0]           mac_cnt_q, mac_len_q;
    logic [ACC_WIDTH-1:0]  acc_q, mac_out_q, dot_sum;
    logic                  mac_done_q;

    logic engine_idle, axi_idle, mac_accept;
    logic aw_hs, w_hs, ar_hs;
    logic [WAW-1:0] ar_idx;
    logic rd_step;

    assign engine_idle = (mac_state_q == MAC_IDLE) && !mac_done_q;
    assign axi_idle    = (wr_state_q == WR_IDLE) && (rd_state_q == RD_IDLE);
    assign mac_accept  = mac_start && engine_idle && axi_idle;

    // mac_start outranks both address channels; AW outranks AR.
    assign s_axi_awready = !rst && s_axi_awvalid && !mac_start && engine_idle && axi_idle;
    assign s_axi_arready = !rst && s_axi_arvalid && !s_axi_awvalid && !mac_start
                           && engine_idle && axi_idle;
    assign s_axi_wready  = !rst && (wr_state_q == WR_DATA);

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;

    assign s_axi_bvalid = (wr_state_q == WR_RESP);
    assign s_axi_bid    = wr_id_q;
    assign s_axi_bresp  = burst_ok(wr_burst_q) ? RESP_OKAY : RESP_SLVERR;

    assign s_axi_rvalid = (rd_state_q == RD_DATA);
    assign s_axi_rid    = rd_id_q;
    assign s_axi_rdata  = rd_data_q;
    assign s_axi_rresp  = burst_ok(rd_burst_q) ? RESP_OKAY : RESP_SLVERR;
    assign s_axi_rlast  = rd_last_q;

    assign mac_busy = (mac_state_q != MAC_IDLE) || mac_done_q;
    assign mac_done = mac_done_q;
    assign mac_out  = mac_out_q;

    assign ar_idx  = s_axi_araddr[ADDR_WIDTH-1:LSB];
    assign rd_step = s_axi_rvalid && s_axi_rready && !rd_last_q;

    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            WR_IDLE: if (aw_hs) wr_state_d = WR_DATA;
            WR_DATA: if (w_hs && s_axi_wlast) wr_state_d = WR_RESP;
            WR_RESP: if (s_axi_bready) wr_state_d = WR_IDLE;
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            RD_IDLE: if (ar_hs) rd_state_d = RD_DATA;
            RD_DATA: if (s_axi_rready && rd_last_q) rd_state_d = RD_IDLE;
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        mac_state_d = mac_state_q;
        case (mac_state_q)
            MAC_IDLE: if (mac_accept && mac_len != 16'd0) mac_state_d = MAC_RD_A;
            MAC_RD_A: mac_state_d = MAC_RD_B;
            MAC_RD_B: mac_state_d = (mac_cnt_q + 16'd1 == mac_len_q) ? MAC_ACC : MAC_RD_A;
            MAC_ACC:  mac_state_d = MAC_DONE;
            MAC_DONE: mac_state_d = MAC_IDLE;
            default:  mac_state_d = MAC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_hs && burst_ok(wr_burst_q)) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (s_axi_wstrb[i]) mem_q[wr_addr_q][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= WR_IDLE;
            wr_id_q    <= '0;
            wr_addr_q  <= '0;
            wr_burst_q <= BURST_INCR;
        end else begin
            wr_state_q <= wr_state_d;
            if (aw_hs) begin
                wr_id_q    <= s_axi_awid;
                wr_addr_q  <= s_axi_awaddr[ADDR_WIDTH-1:LSB];
                wr_burst_q <= s_axi_awburst;
            end else if (w_hs && wr_burst_q == BURST_INCR) begin
                wr_addr_q  <= wr_addr_q + IDX_ONE;
            end
        end
    end

    // rd_addr_q always points at the word for the beat after the one being presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= RD_IDLE;
            rd_id_q    <= '0;
            rd_addr_q  <= '0;
            rd_burst_q <= BURST_INCR;
            rd_len_q   <= '0;
            rd_beat_q  <= '0;
            rd_data_q  <= '0;
            rd_last_q  <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            if (ar_hs) begin
                rd_id_q    <= s_axi_arid;
                rd_burst_q <= s_axi_arburst;
                rd_len_q   <= s_axi_arlen;
                rd_beat_q  <= '0;
                rd_last_q  <= (s_axi_arlen == 8'd0);
                rd_data_q  <= burst_ok(s_axi_arburst) ? mem_q[ar_idx] : '0;
                rd_addr_q  <= (s_axi_arburst == BURST_INCR) ? ar_idx + IDX_ONE : ar_idx;
            end else if (rd_step) begin
                rd_beat_q  <= rd_beat_q + 8'd1;
                rd_last_q  <= (rd_beat_q + 8'd1 == rd_len_q);
                rd_data_q  <= burst_ok(rd_burst_q) ? mem_q[rd_addr_q] : '0;
                if (rd_burst_q == BURST_INCR) rd_addr_q <= rd_addr_q + IDX_ONE;
            end
        end
    end

    axi_pim_dot #(
        .LANES     (STRB_WIDTH),
        .OUT_WIDTH (ACC_WIDTH)
    ) u_dot (
        .a_i   (mac_a_q),
        .b_i   (mac_b_q),
        .sum_o (dot_sum)
    );

    // The product of word k is folded in while word k+1 is being fetched; ACC folds the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            mac_state_q <= MAC_IDLE;
            mac_a_idx_q <= '0;
            mac_b_idx_q <= '0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            mac_cnt_q   <= '0;
            mac_len_q   <= '0;
            acc_q       <= '0;
            mac_out_q   <= '0;
            mac_done_q  <= 1'b0;
        end else begin
            mac_state_q <= mac_state_d;
            mac_done_q  <= 1'b0;
            case (mac_state_q)
                MAC_IDLE: begin
                    if (mac_accept) begin
                        acc_q       <= '0;
                        mac_cnt_q   <= '0;
                        mac_len_q   <= mac_len;
                        mac_a_idx_q <= mac_src_a[ADDR_WIDTH-1:LSB];
                        mac_b_idx_q <= mac_src_b[ADDR_WIDTH-1:LSB];
                        if (mac_len == 16'd0) begin
                            mac_out_q  <= '0;
                            mac_done_q <= 1'b1;
                        end
                    end
                end
                MAC_RD_A: begin
                    mac_a_q     <= mem_q[mac_a_idx_q];
                    mac_a_idx_q <= mac_a_idx_q + IDX_ONE;
                    if (mac_cnt_q != 16'd0) acc_q <= acc_q + dot_sum;
                end
                MAC_RD_B: begin
                    mac_b_q     <= mem_q[mac_b_idx_q];
                    mac_b_idx_q <= mac_b_idx_q + IDX_ONE;
                    mac_cnt_q   <= mac_cnt_q + 16'd1;
                end
                MAC_ACC: acc_q <= acc_q + dot_sum;
                MAC_DONE: begin
                    mac_out_q  <= acc_q;
                    mac_done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{s_axi_awlen, s_axi_awsize, s_axi_awlock, s_axi_awcache, s_axi_awprot,
                             s_axi_awaddr, s_axi_arsize, s_axi_arlock, s_axi_arcache, s_axi_arprot,
                             s_axi_araddr, mac_src_a, mac_src_b};

endmodule

// File: tb/tb_axi_pim_simd.sv
// tb/tb_axi_pim_simd.sv - self-checking bench for axi_pim_simd against a word-array reference model
module tb_axi_pim_simd;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
    logic [11:0] s_axi_awaddr, s_axi_araddr;
    logic [7:0]  s_axi_awlen, s_axi_arlen;
    logic [2:0]  s_axi_awsize, s_axi_arsize, s_axi_awprot, s_axi_arprot;
    logic [1:0]  s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
    logic        s_axi_awlock, s_axi_arlock;
    logic [3:0]  s_axi_awcache, s_axi_arcache;
    logic        s_axi_awvalid, s_axi_awready, s_axi_arvalid, s_axi_arready;
    logic [31:0] s_axi_wdata, s_axi_rdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic        s_axi_bvalid, s_axi_bready;
    logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;
    logic        mac_start, mac_busy, mac_done;
    logic [11:0] mac_src_a, mac_src_b;
    logic [15:0] mac_len;
    logic [39:0] mac_out;

    axi_pim_simd dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
        .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
        .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .mac_start(mac_start), .mac_src_a(mac_src_a), .mac_src_b(mac_src_b), .mac_len(mac_len),
        .mac_busy(mac_busy), .mac_done(mac_done), .mac_out(mac_out)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] ref_mem [1024];
    logic [31:0] wq [256];
    logic [3:0]  sq [256];
    logic [31:0] rd_q [256];
    logic        rl_q [256];
    logic [1:0]  rr_q [256];
    logic [7:0]  ri_q [256];
    logic [1:0]  cap_bresp;
    logic [7:0]  cap_bid;
    bit          first_beat_next;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int word_of(input logic [11:0] addr, input int beat, input logic [1:0] burst);
        if (burst == 2'b01) return ((int'(addr) / 4) + beat) % 1024;
        return int'(addr) / 4;
    endfunction

    function automatic bit legal(input logic [1:0] burst);
        return burst == 2'b00 || burst == 2'b01;
    endfunction

    function automatic void model_write(input logic [11:0] addr, input int n, input logic [1:0] burst);
        int w;
        if (!legal(burst)) return;
        for (int i = 0; i < n; i++) begin
            w = word_of(addr, i, burst);
            for (int l = 0; l < 4; l++)
                if (sq[i][l]) ref_mem[w][8*l +: 8] = wq[i][8*l +: 8];
        end
    endfunction

    function automatic logic [39:0] ref_dot(input logic [11:0] a, input logic [11:0] b, input int len);
        longint s = 0;
        logic [31:0] wa, wb;
        int x, y;
        for (int k = 0; k < len; k++) begin
            wa = ref_mem[(int'(a) / 4 + k) % 1024];
            wb = ref_mem[(int'(b) / 4 + k) % 1024];
            for (int l = 0; l < 4; l++) begin
                x = $signed(wa[8*l +: 8]);
                y = $signed(wb[8*l +: 8]);
                s += longint'(x * y);
            end
        end
        return s[39:0];
    endfunction

    task automatic hs(input int ch, output bit ok);
        bit seen;
        ok = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            case (ch)
                0: seen = s_axi_awready;
                1: seen = s_axi_wready;
                2: seen = s_axi_bvalid;
                default: seen = s_axi_arready;
            endcase
            if (ch == 2 && seen) begin
                cap_bresp = s_axi_bresp;
                cap_bid   = s_axi_bid;
            end
            @(posedge clk); #1;
            if (seen) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wdata_resp(input int n, output bit ok);
        bit r;
        ok = 1;
        for (int i = 0; i < n; i++) begin
            s_axi_wdata = wq[i]; s_axi_wstrb = sq[i]; s_axi_wlast = (i == n - 1); s_axi_wvalid = 1;
            hs(1, r);
            if (!r) ok = 0;
        end
        s_axi_wvalid = 0; s_axi_wlast = 0;
        s_axi_bready = 1;
        hs(2, r);
        if (!r) ok = 0;
        s_axi_bready = 0;
    endtask

    task automatic axi_write(input logic [11:0] addr, input int n, input logic [1:0] burst,
                             input logic [7:0] id, output bit ok);
        bit r1, r2;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = 8'(n - 1);
        s_axi_awburst = burst; s_axi_awvalid = 1;
        hs(0, r1);
        s_axi_awvalid = 0;
        wdata_resp(n, r2);
        ok = r1 && r2;
    endtask

    task automatic axi_read(input logic [11:0] addr, input int n, input logic [1:0] burst,
                            input logic [7:0] id, output bit ok);
        bit r, got;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = 8'(n - 1);
        s_axi_arburst = burst; s_axi_arvalid = 1;
        hs(3, r);
        s_axi_arvalid = 0;
        ok = r;
        first_beat_next = 0;
        for (int i = 0; i < n; i++) begin
            got = 0;
            for (int k = 0; k < 200 && !got; k++) begin
                s_axi_rready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (i == 0 && k == 0) first_beat_next = s_axi_rvalid;
                if (s_axi_rvalid && s_axi_rready) begin
                    got = 1;
                    rd_q[i] = s_axi_rdata; rl_q[i] = s_axi_rlast;
                    rr_q[i] = s_axi_rresp; ri_q[i] = s_axi_rid;
                end
                @(posedge clk); #1;
            end
            if (!got) ok = 0;
        end
        s_axi_rready = 0;
    endtask

    task automatic check_read(input string tag, input logic [11:0] addr, input int n,
                              input logic [1:0] burst, input logic [7:0] id);
        bit ok;
        axi_read(addr, n, burst, id, ok);
        chk({tag, "_rd_done"}, ok, 1);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_rdata%0d", tag, i), rd_q[i],
                legal(burst) ? ref_mem[word_of(addr, i, burst)] : 32'h0);
            chk($sformatf("%s_rresp%0d", tag, i), rr_q[i], legal(burst) ? 2'b00 : 2'b10);
            chk($sformatf("%s_rlast%0d", tag, i), rl_q[i], (i == n - 1));
            chk($sformatf("%s_rid%0d", tag, i), ri_q[i], id);
        end
    endtask

    task automatic mac_run(input logic [11:0] a, input logic [11:0] b, input logic [15:0] len,
                           output int lat, output logic [39:0] out, output bit busy_ok);
        mac_src_a = a; mac_src_b = b; mac_len = len; mac_start = 1;
        @(posedge clk); #1;
        mac_start = 0;
        lat = -1; busy_ok = 1; out = '0;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (!mac_busy) busy_ok = 0;
            if (mac_done) begin
                lat = n;
                out = mac_out;
            end
            @(posedge clk); #1;
            if (lat >= 0) break;
        end
    endtask

    initial begin
        bit ok, blocked, d;
        int lat;
        logic [39:0] out;
        logic [11:0] a, b;
        logic [1:0]  burst;
        int len, n;

        rst = 1;
        s_axi_awid = 0; s_axi_awaddr = 0; s_axi_awlen = 0; s_axi_awsize = 3'd2; s_axi_awburst = 0;
        s_axi_awlock = 0; s_axi_awcache = 0; s_axi_awprot = 0; s_axi_awvalid = 0;
        s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wlast = 0; s_axi_wvalid = 0; s_axi_bready = 0;
        s_axi_arid = 0; s_axi_araddr = 0; s_axi_arlen = 0; s_axi_arsize = 3'd2; s_axi_arburst = 0;
        s_axi_arlock = 0; s_axi_arcache = 0; s_axi_arprot = 0; s_axi_arvalid = 0; s_axi_rready = 0;
        mac_start = 0; mac_src_a = 0; mac_src_b = 0; mac_len = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset_ready_valid",
            {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid}, 5'b0);
        chk("reset_busy_done", {mac_busy, mac_done}, 2'b0);
        chk("reset_mac_out", mac_out, 40'h0);
        @(posedge clk); #1;

        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 256; i++) begin
                wq[i] = $urandom; sq[i] = 4'hF;
            end
            axi_write(12'(blk * 1024), 256, 2'b01, 8'(blk), ok);
            model_write(12'(blk * 1024), 256, 2'b01);
            chk("init_done", ok, 1);
            chk("init_bresp", cap_bresp, 2'b00);
            chk("init_bid", cap_bid, 8'(blk));
        end

        for (int i = 0; i < 4; i++) begin
            wq[i] = 32'hDEADBEEF + 32'(i); sq[i] = 4'hF;
        end
        axi_write(12'h000, 4, 2'b01, 8'h11, ok);
        model_write(12'h000, 4, 2'b01);
        chk("incr4_bresp", cap_bresp, 2'b00);
        chk("incr4_bid", cap_bid, 8'h11);
        check_read("incr4", 12'h000, 4, 2'b01, 8'h22);
        chk("incr4_first_beat_latency", first_beat_next, 1);
        chk("incr4_literal_beat3", rd_q[3], 32'hDEADBEF2);

        wq[0] = 32'h0; sq[0] = 4'hF;
        axi_write(12'h080, 1, 2'b01, 8'h01, ok);
        model_write(12'h080, 1, 2'b01);
        wq[0] = 32'hFFFFFFFF; sq[0] = 4'b0101;
        axi_write(12'h080, 1, 2'b01, 8'h02, ok);
        model_write(12'h080, 1, 2'b01);
        axi_read(12'h080, 1, 2'b01, 8'h03, ok);
        chk("strobe_0101", rd_q[0], 32'h00FF00FF);

        wq[0] = 32'h12345678; wq[1] = 32'h9ABCDEF0; sq[0] = 4'hF; sq[1] = 4'hF;
        axi_write(12'h010, 2, 2'b10, 8'h33, ok);
        model_write(12'h010, 2, 2'b10);
        chk("wrap_bresp", cap_bresp, 2'b10);
        chk("wrap_bid", cap_bid, 8'h33);
        check_read("wrap_untouched", 12'h010, 2, 2'b01, 8'h34);
        check_read("wrap_read", 12'h010, 3, 2'b10, 8'h35);

        for (int i = 0; i < 4; i++) begin
            wq[i] = $urandom; sq[i] = 4'($urandom_range(1, 15));
        end
        axi_write(12'hFF8, 4, 2'b01, 8'h40, ok);
        model_write(12'hFF8, 4, 2'b01);
        check_read("incr_wrap_mem", 12'hFF8, 4, 2'b01, 8'h41);
        axi_write(12'h044, 3, 2'b00, 8'h42, ok);
        model_write(12'h044, 3, 2'b00);
        check_read("fixed", 12'h044, 2, 2'b00, 8'h43);

        for (int t = 0; t < 24; t++) begin
            a = 12'($urandom_range(0, 1023) * 4);
            len = $urandom_range(1, 8);
            n = $urandom_range(0, 9);
            burst = (n < 4) ? 2'b01 : (n < 7) ? 2'b00 : (n < 8) ? 2'b10 : 2'b11;
            if (t % 2 == 0) begin
                for (int i = 0; i < len; i++) begin
                    wq[i] = $urandom; sq[i] = 4'($urandom);
                end
                axi_write(a, len, burst, 8'(t), ok);
                model_write(a, len, burst);
                chk("rand_wr_done", ok, 1);
                chk("rand_bresp", cap_bresp, legal(burst) ? 2'b00 : 2'b10);
            end else begin
                check_read("rand", a, len, burst, 8'(t));
            end
        end

        wq[0] = 32'h01020304; wq[1] = 32'hFF000000; sq[0] = 4'hF; sq[1] = 4'hF;
        axi_write(12'h100, 2, 2'b01, 8'h50, ok);
        model_write(12'h100, 2, 2'b01);
        wq[0] = 32'h01010101; wq[1] = 32'h02000000;
        axi_write(12'h200, 2, 2'b01, 8'h51, ok);
        model_write(12'h200, 2, 2'b01);
        mac_run(12'h100, 12'h200, 16'd2, lat, out, ok);
        chk("mac2_latency", lat, 7);
        chk("mac2_out", out, 40'd8);
        chk("mac2_model", out, ref_dot(12'h100, 12'h200, 2));
        chk("mac2_busy", ok, 1);
        @(negedge clk);
        chk("mac2_busy_after", mac_busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("mac2_out_hold", mac_out, 40'd8);

        mac_run(12'h300, 12'h400, 16'd0, lat, out, ok);
        chk("mac0_latency", lat, 1);
        chk("mac0_out", out, 40'd0);

        for (int t = 0; t < 6; t++) begin
            a = 12'($urandom_range(0, 1023) * 4);
            b = (t < 2) ? 12'hFF0 : 12'($urandom_range(0, 1023) * 4);
            len = $urandom_range(1, 24);
            mac_run(a, b, 16'(len), lat, out, ok);
            chk($sformatf("mac_rand%0d_latency", t), lat, 2 * len + 3);
            chk($sformatf("mac_rand%0d_out", t), out, ref_dot(a, b, len));
            chk($sformatf("mac_rand%0d_busy", t), ok, 1);
        end

        wq[0] = $urandom; wq[1] = $urandom; sq[0] = 4'hF; sq[1] = 4'hF;
        mac_src_a = 12'h100; mac_src_b = 12'h200; mac_len = 16'd3; mac_start = 1;
        s_axi_awid = 8'h5A; s_axi_awaddr = 12'h300; s_axi_awlen = 8'd1;
        s_axi_awburst = 2'b01; s_axi_awvalid = 1;
        blocked = 1; lat = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (s_axi_awready) blocked = 0;
            d = mac_done;
            @(posedge clk); #1;
            mac_start = 0;
            if (d) begin
                lat = k;
                break;
            end
        end
        chk("aw_blocked_during_mac", blocked, 1);
        chk("aw_block_mac_latency", lat, 9);
        @(negedge clk);
        chk("aw_ready_after_done", s_axi_awready, 1);
        @(posedge clk); #1;
        s_axi_awvalid = 0;
        wdata_resp(2, ok);
        model_write(12'h300, 2, 2'b01);
        chk("aw_after_mac_done", ok, 1);
        chk("aw_after_mac_bresp", cap_bresp, 2'b00);
        chk("aw_after_mac_bid", cap_bid, 8'h5A);
        check_read("aw_after_mac", 12'h300, 2, 2'b01, 8'h5B);

        mac_src_a = 12'h400; mac_src_b = 12'h800; mac_len = 16'd10; mac_start = 1;
        @(posedge clk); #1;
        mac_start = 0;
        repeat (5) @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_mid_mac_busy", mac_busy, 0);
        chk("rst_mid_mac_out", mac_out, 40'd0);
        chk("rst_mid_mac_done", mac_done, 0);
        @(posedge clk); #1;
        check_read("after_rst", 12'h000, 8, 2'b01, 8'h60);
        check_read("after_rst_strb", 12'h080, 1, 2'b01, 8'h61);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
